// File: rtl/vk_reset_seq.sv
`default_nettype none
// ============================================================================
// Module  : vk_reset_seq
// Brief   : Reset release sequencer: synchronizes areset_i, holds the datapath
//           in reset for HOLD_CYCLES clocks, optionally sweeps the search RAM
//           with zero writes (enable with macro VK_RESET_SEQ_CLEAR_EN), then
//           raises sreset_o/ready_o. soft_rst_i in DONE re-runs the sequence.
// Revision: 1.0 - initial release
// ============================================================================
module vk_reset_seq #(
    parameter int HOLD_CYCLES = 16,
    parameter int ADDR_W      = 10
) (
    input  logic              clk_i,
    input  logic              areset_i,
    input  logic              soft_rst_i,
    input  logic              clr_rdy_i,
    output logic              sreset_o,
    output logic              ready_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    localparam int                 c_CNT_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);

    localparam logic [1:0] c_ST_HOLD  = 2'd0;
    localparam logic [1:0] c_ST_CLEAR = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

`ifdef VK_RESET_SEQ_CLEAR_EN
    localparam logic [ADDR_W-1:0] c_ADDR_LAST = {ADDR_W{1'b1}};
`else
    logic w_unused_rdy;
    assign w_unused_rdy = clr_rdy_i;
`endif

    logic               r_sync;
    logic               r_sync_del;
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_we;
    logic               r_sreset;
    logic               r_ready;

    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic               w_we_nxt;

    always_ff @(posedge clk_i or negedge areset_i) begin
        if (!areset_i) begin
            r_sync     <= 1'b0;
            r_sync_del <= 1'b0;
        end else begin
            r_sync     <= 1'b1;
            r_sync_del <= r_sync;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_we_nxt    = r_we;
        case (r_state)
            c_ST_HOLD: begin
                // Hold only advances once the synchronized release is seen
                if (r_sync_del) begin
                    if (r_cnt == c_HOLD_LAST) begin
                        w_cnt_nxt = '0;
`ifdef VK_RESET_SEQ_CLEAR_EN
                        w_state_nxt = c_ST_CLEAR;
                        w_we_nxt    = 1'b1;
                        w_addr_nxt  = '0;
`else
                        w_state_nxt = c_ST_DONE;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            c_ST_CLEAR: begin
`ifdef VK_RESET_SEQ_CLEAR_EN
                // Last accepted word ends the sweep; address stays, no wrap
                if (r_we && clr_rdy_i) begin
                    if (r_addr == c_ADDR_LAST) begin
                        w_state_nxt = c_ST_DONE;
                        w_we_nxt    = 1'b0;
                    end else begin
                        w_addr_nxt = r_addr + 1'b1;
                    end
                end
`else
                w_state_nxt = c_ST_DONE;
                w_we_nxt    = 1'b0;
`endif
            end
            c_ST_DONE: begin
                if (soft_rst_i) begin
                    w_state_nxt = c_ST_HOLD;
                    w_cnt_nxt   = '0;
                    w_addr_nxt  = '0;
                    w_we_nxt    = 1'b0;
                end
            end
            default: begin
                w_state_nxt = c_ST_HOLD;
                w_cnt_nxt   = '0;
                w_addr_nxt  = '0;
                w_we_nxt    = 1'b0;
            end
        endcase
    end

    // Outputs are registered from the next state so they track DONE exactly
    always_ff @(posedge clk_i or negedge areset_i) begin
        if (!areset_i) begin
            r_state  <= c_ST_HOLD;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_sreset <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_addr   <= w_addr_nxt;
            r_we     <= w_we_nxt;
            r_sreset <= (w_state_nxt == c_ST_DONE);
            r_ready  <= (w_state_nxt == c_ST_DONE);
        end
    end

    assign sreset_o   = r_sreset;
    assign ready_o    = r_ready;
    assign clr_we_o   = r_we;
    assign clr_addr_o = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_vk_reset_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_vk_reset_seq
// Brief   : Directed self-checking bench for vk_reset_seq (HOLD_CYCLES=4,
//           ADDR_W=3); expectations follow VK_RESET_SEQ_CLEAR_EN if defined.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vk_reset_seq;

    localparam int HOLD_CYCLES = 4;
    localparam int ADDR_W      = 3;

`ifdef VK_RESET_SEQ_CLEAR_EN
    localparam int c_LAT       = 14;
    localparam int c_SOFT_LAT  = 12;
    localparam int c_ABORT_AT  = 9;
    localparam int c_STALL_LAT = 17;
`else
    localparam int c_LAT       = 6;
    localparam int c_SOFT_LAT  = 4;
    localparam int c_ABORT_AT  = 4;
    localparam int c_STALL_LAT = 6;
`endif

    logic              clk_i;
    logic              areset_i;
    logic              soft_rst_i;
    logic              clr_rdy_i;
    logic              sreset_o;
    logic              ready_o;
    logic              clr_we_o;
    logic [ADDR_W-1:0] clr_addr_o;

    int total = 0;
    int bad   = 0;

    vk_reset_seq #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk_i      (clk_i),
        .areset_i   (areset_i),
        .soft_rst_i (soft_rst_i),
        .clr_rdy_i  (clr_rdy_i),
        .sreset_o   (sreset_o),
        .ready_o    (ready_o),
        .clr_we_o   (clr_we_o),
        .clr_addr_o (clr_addr_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sreset"}, {31'd0, sreset_o}, 32'd0);
        chk({tag, "_ready"},  {31'd0, ready_o},  32'd0);
        chk({tag, "_we"},     {31'd0, clr_we_o}, 32'd0);
        chk({tag, "_addr"},   {29'd0, clr_addr_o}, 32'd0);
    endtask

    // Releases areset_i at a falling edge and walks stop_at rising edges.
    // clr_rdy_i is low on edges stall_at+1 .. stall_at+stall_len.
    task automatic run_seq(input int stall_at, input int stall_len, input int stop_at);
        int  acc;
        bit  clr;
        bit  done;
        bit  rdy;
        acc  = 0;
        clr  = 1'b0;
        done = 1'b0;
        areset_i = 1'b1;
        #1;
        chk_all_zero("release");
        for (int n = 1; n <= stop_at; n++) begin
            rdy = !(n > stall_at && n <= stall_at + stall_len);
            clr_rdy_i = rdy;
            step();
`ifdef VK_RESET_SEQ_CLEAR_EN
            if (clr && rdy) begin
                if (acc == 7) begin
                    clr  = 1'b0;
                    done = 1'b1;
                end else begin
                    acc++;
                end
            end
            if (n == 6) clr = 1'b1;
            chk($sformatf("seq_we_e%0d", n), {31'd0, clr_we_o}, {31'd0, clr});
            if (clr) chk($sformatf("seq_addr_e%0d", n), {29'd0, clr_addr_o}, acc);
`else
            done = (n >= 6);
            chk($sformatf("seq_we_e%0d", n), {31'd0, clr_we_o}, 32'd0);
            chk($sformatf("seq_addr_e%0d", n), {29'd0, clr_addr_o}, 32'd0);
`endif
            chk($sformatf("seq_sreset_e%0d", n), {31'd0, sreset_o}, {31'd0, done});
            chk($sformatf("seq_ready_e%0d", n),  {31'd0, ready_o},  {31'd0, done});
        end
        clr_rdy_i = 1'b1;
    endtask

    initial begin
        areset_i   = 1'b0;
        soft_rst_i = 1'b0;
        clr_rdy_i  = 1'b1;
        repeat (3) step();
        chk_all_zero("reset");

        // Power-up sequence with RAM always ready
        run_seq(1000, 0, c_LAT);
        step();
        chk("done_hold_sreset", {31'd0, sreset_o}, 32'd1);
        chk("done_hold_we",     {31'd0, clr_we_o}, 32'd0);

        // Soft reset from DONE, with later pulses that must be ignored
        soft_rst_i = 1'b1;
        step();
        soft_rst_i = 1'b0;
        chk("soft_k_sreset", {31'd0, sreset_o}, 32'd0);
        chk("soft_k_ready",  {31'd0, ready_o},  32'd0);
        chk("soft_k_addr",   {29'd0, clr_addr_o}, 32'd0);
        for (int j = 1; j <= c_SOFT_LAT; j++) begin
            if (j == 2) soft_rst_i = 1'b1;
`ifdef VK_RESET_SEQ_CLEAR_EN
            if (j == 6) soft_rst_i = 1'b1;
`endif
            step();
            soft_rst_i = 1'b0;
            chk($sformatf("soft_sreset_k%0d", j), {31'd0, sreset_o},
                {31'd0, (j >= c_SOFT_LAT)});
`ifdef VK_RESET_SEQ_CLEAR_EN
            chk($sformatf("soft_we_k%0d", j), {31'd0, clr_we_o},
                {31'd0, (j >= 4 && j < 12)});
            if (j == 4) chk("soft_clr_addr0", {29'd0, clr_addr_o}, 32'd0);
`else
            chk($sformatf("soft_we_k%0d", j), {31'd0, clr_we_o}, 32'd0);
`endif
        end

        // Asynchronous abort mid-sequence, then full restart
        areset_i = 1'b0;
        @(negedge clk_i);
        run_seq(1000, 0, c_ABORT_AT);
`ifdef VK_RESET_SEQ_CLEAR_EN
        chk("abort_pre_addr", {29'd0, clr_addr_o}, 32'd3);
`endif
        #2 areset_i = 1'b0;
        #1;
        chk_all_zero("abort_async");
        @(negedge clk_i);
        run_seq(1000, 0, c_LAT);

        // Restart with the RAM stalling three cycles at address 5
        areset_i = 1'b0;
        @(negedge clk_i);
        run_seq(11, 3, c_STALL_LAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
